// File: rtl/inst_mem_block_if.sv
// Instruction-memory bus: fetch address/data plus the optional load port.
// The memory side uses the slave modport; the driver of PC and the load port uses master.
interface inst_mem_block_if;
  logic [31:0] PC;
  logic [31:0] Instruction_Code;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  modport master (output PC, load_en, load_addr, load_data, input Instruction_Code);
  modport slave  (input PC, load_en, load_addr, load_data, output Instruction_Code);
endinterface

// File: rtl/inst_mem_block.sv
// Instruction memory with a combinational read port and an optional load port.
// Define INST_MEM_LOAD_EN to enable loading; otherwise the block is a pure ROM.
module inst_mem_block #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  inst_mem_block_if.slave   bus
);
  localparam int          AW  = $clog2(DEPTH_WORDS);
  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic [31:0] dflt_word(input logic [AW-1:0] idx);
    logic [31:0] w;
    w = NOP;
    if (idx == AW'(0)) w = 32'h0050_0093;
    if (idx == AW'(1)) w = 32'h00A0_0113;
    if (idx == AW'(2)) w = 32'h0020_81B3;
    return w;
  endfunction

  logic [AW-1:0] rd_idx;
  logic          rd_inr;
  logic [31:0]   rd_word;

  // PC[1:0] is dropped, so misaligned fetches return the enclosing word.
  assign rd_idx = bus.PC[AW+1:2];
  assign rd_inr = (bus.PC[31:AW+2] == '0);

`ifdef INST_MEM_LOAD_EN
  logic [DEPTH_WORDS-1:0][31:0] mem_q;
  logic [AW-1:0]                wr_idx;
  logic                         wr_inr;
  logic                         unused_lo;

  assign wr_idx    = bus.load_addr[AW+1:2];
  assign wr_inr    = (bus.load_addr[31:AW+2] == '0);
  assign unused_lo = ^bus.load_addr[1:0];

  // Reset rebuilds the default program and masks any load on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= dflt_word(AW'(i));
    end else if (bus.load_en && wr_inr) begin
      mem_q[wr_idx] <= bus.load_data;
    end
  end

  assign rd_word = mem_q[rd_idx];
`else
  logic unused_ld;
  assign unused_ld = ^{clk, bus.load_en, bus.load_addr, bus.load_data};
  assign rd_word   = dflt_word(rd_idx);
`endif

  assign bus.Instruction_Code = (reset || !rd_inr) ? NOP : rd_word;
endmodule

// File: tb/tb_inst_mem_block.sv
// Randomized scoreboard bench for inst_mem_block against an array-based reference model.
module tb_inst_mem_block;
  localparam int          DEPTH = 256;
  localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef INST_MEM_LOAD_EN
  localparam bit LOADABLE = 1'b1;
`else
  localparam bit LOADABLE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  inst_mem_block_if bus ();

  inst_mem_block #(.DEPTH_WORDS(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] model [DEPTH];
  logic [31:0] exp_q [$];
  string       name_q [$];
  int          checks = 0;
  int          errors = 0;
  bit          chk_vld = 1'b0;

  function automatic void model_reset();
    foreach (model[i]) model[i] = NOP;
    model[0] = 32'h0050_0093;
    model[1] = 32'h00A0_0113;
    model[2] = 32'h0020_81B3;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] pc);
    if (pc >= 32'(4 * DEPTH)) return NOP;
    return model[pc / 4];
  endfunction

  // One clock period of stimulus; the expected fetch is queued before any load lands.
  task automatic cycle(input bit r, input logic [31:0] pc, input bit le,
                       input logic [31:0] la, input logic [31:0] ld,
                       input bit chk, input string nm);
    @(posedge clk);
    #1;
    reset         = r;
    bus.PC        = pc;
    bus.load_en   = le;
    bus.load_addr = la;
    bus.load_data = ld;
    if (r) model_reset();
    chk_vld = chk;
    if (chk) begin
      exp_q.push_back(r ? NOP : model_read(pc));
      name_q.push_back(nm);
    end
    if (!r && le && LOADABLE && la < 32'(4 * DEPTH)) model[la / 4] = ld;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 31));
      1:       return 32'($urandom_range(0, 4 * DEPTH - 1));
      2:       return 32'($urandom_range(4 * DEPTH - 8, 4 * DEPTH + 7));
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_vld) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL queue_underflow: monitor saw a check with no expectation");
      end else begin
        logic [31:0] e;
        string       n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if (bus.Instruction_Code !== e) begin
          errors++;
          $display("FAIL %s: PC=%h got %h expected %h", n, bus.PC, bus.Instruction_Code, e);
        end
      end
    end
  end

  initial begin
    bus.PC        = '0;
    bus.load_en   = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    model_reset();

    cycle(1, 32'h0,   0, 0, 0, 1, "reset_nop");
    cycle(0, 32'h0,   0, 0, 0, 1, "word0");
    cycle(0, 32'h4,   0, 0, 0, 1, "word1");
    cycle(0, 32'h8,   0, 0, 0, 1, "word2");
    cycle(0, 32'hC,   0, 0, 0, 1, "word3_nop");
    cycle(0, 32'h3FC, 0, 0, 0, 1, "last_word_nop");
    cycle(0, 32'h400, 0, 0, 0, 1, "out_of_range");
    cycle(0, 32'h6,   0, 0, 0, 1, "misaligned");
    // Load word 1; the same-cycle read still shows the old value.
    cycle(0, 32'h4, 1, 32'h4, 32'hDEAD_BEEF, 1, "read_before_load");
    cycle(0, 32'h4, 0, 0, 0, 1, "read_after_load");
    cycle(1, 32'h4, 0, 0, 0, 1, "reset_pulse");
    cycle(0, 32'h4, 0, 0, 0, 1, "restored_word1");
    // Load held across an edge while reset is high must be discarded.
    cycle(1, 32'h4, 1, 32'h4, 32'h1234_5678, 1, "load_in_reset");
    cycle(1, 32'h4, 1, 32'h4, 32'h1234_5678, 1, "load_in_reset2");
    cycle(0, 32'h4, 0, 0, 0, 1, "no_write_in_reset");
    cycle(0, 32'h0, 0, 0, 0, 1, "after_reset_word0");
    cycle(1, 32'h0, 0, 0, 0, 1, "async_reset_nop");
    cycle(0, 32'h0, 1, 32'h403, 32'hCAFE_F00D, 1, "oor_load_issue");
    cycle(0, 32'h0, 0, 0, 0, 1, "oor_load_dropped");
    cycle(0, 32'h3, 0, 0, 0, 1, "oor_alias_word0");

    for (int i = 0; i < 600; i++) begin
      bit r;
      r = ($urandom_range(0, 24) == 0);
      cycle(r, rand_addr(), 1'($urandom_range(0, 1)), rand_addr(), $urandom, 1, "random");
    end

    @(posedge clk);
    #1;
    chk_vld = 1'b0;
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_mem_block.md
INST_MEM_BLOCK -- requirements
Module: INST_MEM

Interface
REQ-001 The module SHALL have parameter DEPTH_WORDS, default 256, giving the memory depth in 32-bit words (power of two, 4..4096).
REQ-002 clk  input  1  The single clock; it is used only by the load port.
REQ-003 reset  input  1  Asynchronous, active-high reset.
REQ-004 PC  input  32  Byte address of the instruction to fetch.
REQ-005 Instruction_Code  output  32  Instruction word at PC.
REQ-006 load_en  input  1  Load-port write strobe; it is active only with INST_MEM_LOAD_EN.
REQ-007 load_addr  input  32  Load-port byte address.
REQ-008 load_data  input  32  Load-port instruction word.

Function
REQ-009 Storage SHALL be DEPTH_WORDS words, addressed by word index = PC[log2(DEPTH_WORDS)+1:2].
REQ-010 PC[1:0] SHALL be ignored, so any misaligned PC fetches the enclosing aligned word.
REQ-011 The read path SHALL be combinational: Instruction_Code follows PC and memory contents in the same time step, with zero clock latency.
REQ-012 If PC >= 4*DEPTH_WORDS (out of range), Instruction_Code SHALL be 0x00000013 (NOP).
REQ-013 While reset=1, Instruction_Code SHALL be 0x00000013, regardless of PC.
REQ-014 The default program SHALL be: word0=0x00500093 (addi x1,x0,5), word1=0x00A00113 (addi x2,x0,10), word2=0x002081B3 (add x3,x1,x2), and every other word 0x00000013.
REQ-015 Loading SHALL take effect on the rising edge of clk when load_en=1 and reset=0: mem[load_addr word index] <= load_data.
REQ-016 load_addr[1:0] SHALL be ignored, and an out-of-range load_addr SHALL be dropped with no write.
REQ-017 Read-during-load at the same word: before the edge, Instruction_Code shows the old value; after the edge, it shows load_data.
REQ-018 There SHALL be no other state, handshake or FSM; the block is a memory with an optional one-cycle write.

Reset
REQ-019 Assertion of reset SHALL asynchronously restore all words to the default program of REQ-014, discarding prior loads.
REQ-020 Reset SHALL have priority over a simultaneous load: no write occurs on any clk edge while reset=1.
REQ-021 After reset deasserts, fetches SHALL return the default program immediately, without waiting for a clock edge.

Configuration
REQ-022 Macro INST_MEM_LOAD_EN SHALL control the load port.
- Defined: the load port operates per REQ-015..REQ-017.
- Undefined: load_en, load_addr and load_data are present but ignored, clk has no effect, and the memory is a pure ROM holding the default program.

Verification
REQ-023 Reset=1 with PC=0, then reset=0 and PC=0x0 -> Instruction_Code=0x00500093; PC=0x4 -> 0x00A00113; PC=0x8 -> 0x002081B3.
REQ-024 PC=0xC, then PC=0x3FC -> 0x00000013 both times; PC=0x400 with DEPTH_WORDS=256 (out of range) -> 0x00000013.
REQ-025 PC=0x6 -> 0x00A00113, because the misaligned address resolves to word 1.
REQ-026 With INST_MEM_LOAD_EN defined: load_en=1, load_addr=0x4, load_data=0xDEADBEEF, then one clk edge -> PC=0x4 reads 0xDEADBEEF; pulsing reset -> PC=0x4 reads 0x00A00113 again.
REQ-027 With INST_MEM_LOAD_EN defined: load_en=1 held with reset=1 across a clk edge -> no write occurs, and after reset PC=0x4 reads 0x00A00113; reset asserted mid-run with PC=0x0 -> output 0x00000013 immediately.
REQ-028 With INST_MEM_LOAD_EN undefined: the same load sequence as REQ-026 -> PC=0x4 still reads 0x00A00113.
